// File: rtl/scarv_cop_perm_stage.sv
// Sequencing stage in front of the combinational permutation unit: registers the
// decoded instruction, runs one execute cycle, then holds the CPR write until acked.
module scarv_cop_perm_stage #(
    parameter int CNT_W = 16
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             flush,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [31:0]      id_rs1,
    input  logic [31:0]      id_rs3,
    input  logic [31:0]      id_imm,
    input  logic [15:0]      id_subclass,
    input  logic [3:0]       id_rd,
    output logic             perm_ivalid,
    output logic [31:0]      perm_rs1,
    output logic [31:0]      perm_rs3,
    output logic [31:0]      perm_imm,
    output logic [15:0]      perm_subclass,
    input  logic             perm_idone,
    input  logic [3:0]       perm_cpr_rd_ben,
    input  logic [31:0]      perm_cpr_rd_wdata,
    output logic             cpr_rd_wen,
    output logic [3:0]       cpr_rd_addr,
    output logic [3:0]       cpr_rd_ben,
    output logic [31:0]      cpr_rd_wdata,
    input  logic             cpr_rd_ack,
    output logic             id_exception,
    output logic [CNT_W-1:0] retired
);

    localparam int SCLASS_PERM_BIT  = 0;
    localparam int SCLASS_PERM_IBIT = 1;
    localparam int SCLASS_PERM_BYTE = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2,
        ST_EXC  = 2'd3
    } state_t;

    state_t           state_r;
    logic             perm_ivalid_r;
    logic [31:0]      rs1_r;
    logic [31:0]      rs3_r;
    logic [31:0]      imm_r;
    logic [15:0]      subclass_r;
    logic [3:0]       rd_r;
    logic             cpr_wen_r;
    logic [3:0]       cpr_addr_r;
    logic [3:0]       cpr_ben_r;
    logic [31:0]      cpr_wdata_r;
    logic             exc_r;
    logic [CNT_W-1:0] retired_r;

    logic             ready_s;
    logic             accept_s;
    logic             legal_s;

    function automatic logic exactly_one3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    assign ready_s  = g_resetn & ~flush &
                      ((state_r == ST_IDLE) | ((state_r == ST_WB) & cpr_rd_ack));
    assign accept_s = ready_s & id_valid;
    assign legal_s  = exactly_one3({id_subclass[SCLASS_PERM_BYTE],
                                    id_subclass[SCLASS_PERM_IBIT],
                                    id_subclass[SCLASS_PERM_BIT]});

    // Operand registers double as the permute-unit drive: they are only non-zero in EXEC.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_r       <= ST_IDLE;
            perm_ivalid_r <= 1'b0;
            rs1_r         <= 32'd0;
            rs3_r         <= 32'd0;
            imm_r         <= 32'd0;
            subclass_r    <= 16'd0;
            rd_r          <= 4'd0;
            cpr_wen_r     <= 1'b0;
            cpr_addr_r    <= 4'd0;
            cpr_ben_r     <= 4'd0;
            cpr_wdata_r   <= 32'd0;
            exc_r         <= 1'b0;
            retired_r     <= {CNT_W{1'b0}};
        end else if (flush) begin
            state_r       <= ST_IDLE;
            perm_ivalid_r <= 1'b0;
            rs1_r         <= 32'd0;
            rs3_r         <= 32'd0;
            imm_r         <= 32'd0;
            subclass_r    <= 16'd0;
            cpr_wen_r     <= 1'b0;
            cpr_addr_r    <= 4'd0;
            cpr_ben_r     <= 4'd0;
            cpr_wdata_r   <= 32'd0;
            exc_r         <= 1'b0;
        end else begin
            exc_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_EXEC: begin
                    if (perm_idone) begin
                        state_r       <= ST_WB;
                        cpr_wen_r     <= 1'b1;
                        cpr_addr_r    <= rd_r;
                        cpr_ben_r     <= perm_cpr_rd_ben;
                        cpr_wdata_r   <= perm_cpr_rd_wdata;
                        perm_ivalid_r <= 1'b0;
                        rs1_r         <= 32'd0;
                        rs3_r         <= 32'd0;
                        imm_r         <= 32'd0;
                        subclass_r    <= 16'd0;
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_WB: begin
                    if (cpr_rd_ack) begin
                        state_r     <= ST_IDLE;
                        retired_r   <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        cpr_wen_r   <= 1'b0;
                        cpr_addr_r  <= 4'd0;
                        cpr_ben_r   <= 4'd0;
                        cpr_wdata_r <= 32'd0;
                    end else begin
                        state_r <= ST_WB;
                    end
                end
                ST_EXC: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            // A new instruction may arrive from IDLE or in the ack cycle of WB.
            if (accept_s) begin
                rd_r <= id_rd;
                if (legal_s) begin
                    state_r       <= ST_EXEC;
                    perm_ivalid_r <= 1'b1;
                    rs1_r         <= id_rs1;
                    rs3_r         <= id_rs3;
                    imm_r         <= id_imm;
                    subclass_r    <= id_subclass;
                end else begin
                    state_r <= ST_EXC;
                    exc_r   <= 1'b1;
                end
            end
        end
    end

    assign id_ready      = ready_s;
    assign perm_ivalid   = perm_ivalid_r;
    assign perm_rs1      = rs1_r;
    assign perm_rs3      = rs3_r;
    assign perm_imm      = imm_r;
    assign perm_subclass = subclass_r;
    assign cpr_rd_wen    = cpr_wen_r;
    assign cpr_rd_addr   = cpr_addr_r;
    assign cpr_rd_ben    = cpr_ben_r;
    assign cpr_rd_wdata  = cpr_wdata_r;
    assign id_exception  = exc_r;
    assign retired       = retired_r;

endmodule

// File: doc/scarv_cop_perm_stage.md
# scarv_cop_perm_stage

Sequencing stage that sits directly upstream of the permutation unit (xc.pbit, xc.ipbit, xc.pbyte) and also owns its result path to the CPR file. It accepts a decoded permute instruction over a valid/ready handshake and registers the operands. It drives the combinational permutation unit for one execute cycle, then captures the result and holds a CPR write request until the register file acknowledges it. It also flags illegal subclass encodings and counts retired instructions.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- g_clk  in  1  core clock; all state on rising edge
- g_resetn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of any in-flight instruction
- id_valid  in  1  decoded permute instruction offered
- id_ready  out  1  stage accepts instruction this cycle
- id_rs1  in  32  CPR rs1 value (mask / pbyte source)
- id_rs3  in  32  CPR rs3 value (pbit/ipbit source)
- id_imm  in  32  instruction immediate
- id_subclass  in  16  subclass one-hot (SCARV_COP_SCLASS_PERM_BIT/IBIT/BYTE)
- id_rd  in  4  destination CPR index
- perm_ivalid  out  1  to permute unit: execute
- perm_rs1  out  32  to permute unit
- perm_rs3  out  32  to permute unit
- perm_imm  out  32  to permute unit id_imm
- perm_subclass  out  16  to permute unit id_subclass
- perm_idone  in  1  from permute unit
- perm_cpr_rd_ben  in  4  from permute unit
- perm_cpr_rd_wdata  in  32  from permute unit
- cpr_rd_wen  out  1  CPR write request
- cpr_rd_addr  out  4  CPR write index
- cpr_rd_ben  out  4  CPR byte enables
- cpr_rd_wdata  out  32  CPR write data
- cpr_rd_ack  in  1  CPR write accepted this cycle
- id_exception  out  1  one-cycle pulse: illegal subclass
- retired  out  CNT_W  count of completed CPR writes

## Operation
- States: IDLE, EXEC, WB, EXC. Reset state IDLE.
- IDLE: id_ready=1. On id_valid: latch rs1, rs3, imm, subclass, rd. Legal iff exactly one of the three PERM subclass bits set (other bits ignored). Legal -> EXEC; illegal -> EXC.
- EXEC: perm_ivalid=1; perm_* driven from latched regs. When perm_idone=1: capture perm_cpr_rd_wdata and perm_cpr_rd_ben -> WB. perm_idone=0 -> remain in EXEC.
- WB: cpr_rd_wen=1, addr/ben/wdata from capture regs, held stable until cpr_rd_ack. On ack: retired increments (wraps modulo 2^CNT_W); id_ready=1 same cycle; if id_valid also set, latch the new instruction -> EXEC/EXC, else -> IDLE.
- EXC: id_exception=1 for exactly one cycle, no CPR write, no counter change -> IDLE. id_ready=0.
- id_ready = (IDLE) | (WB & cpr_rd_ack), and is forced 0 while flush=1.
- Outside EXEC, perm_ivalid, perm_rs1, perm_rs3, perm_imm and perm_subclass are all driven 0 (toggle suppression).
- flush (any state): next state IDLE. A WB write pending without ack is dropped, and ack arriving in the flush cycle is ignored (no count). An EXC pulse in progress still completes this cycle. No instruction is accepted in the flush cycle.
- Register write to rd 0 is issued like any other; CPR file decides.

## Timing
- Reset values: id_ready=0 during reset, 1 after (IDLE); perm_ivalid=0; perm_* all 0; cpr_rd_wen=0, addr/ben/wdata=0; id_exception=0; retired=0.
- Latency: accept at cycle N -> perm_ivalid cycle N+1 -> cpr_rd_wen from cycle N+2. With immediate ack, next accept is at N+2; peak throughput 1 instruction / 2 cycles.
- Illegal: accept at N -> id_exception high during N+1 -> id_ready high at N+2.
- cpr_rd_* are registered outputs; no combinational path from id_* to cpr_rd_*, or from cpr_rd_ack to perm_*.
- Reset asserted mid-operation: immediate return to IDLE values; no partial write is visible.

## Test plan
- pbyte: rs1=0x44332211, imm=0x390, rd=5, ack held 1 -> cpr_rd_wen at N+2, wdata=0x11223344, ben=0xF, addr=5, retired=1.
- pbit, cs=0: rs3=0xDEADBEEF, imm=0 -> wdata=0xDEADBEEF; back-to-back id_valid accepted in the ack cycle, second write 2 cycles later.
- WB backpressure: ack low for 4 cycles -> cpr_rd_* stable, id_ready=0, retired unchanged; ack -> single count.
- Illegal subclass (0 or BIT|BYTE) -> one-cycle id_exception, no cpr_rd_wen, retired unchanged.
- flush in WB with ack asserted same cycle -> IDLE next, no count; flush in EXEC -> no write.
- CNT_W=2: 5 retirements -> retired wraps to 1; g_resetn pulse mid-EXEC -> all outputs at reset values.
